datapath_ctrl: RTL
==================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port s, input, 1 bit: start request, sampled only in WAIT.
REQ-004 The block SHALL have the port in, input, 16 bits: instruction word, captured on an accepted start.
REQ-005 The block SHALL have the port w, output, 1 bit: idle/ready; high exactly when in WAIT.
REQ-006 The block SHALL have the port err, output, 1 bit: sticky illegal-instruction flag.
REQ-007 The block SHALL have the port nsel, output, 3 bits: register-select, one-hot; 100=Rn, 010=Rd, 001=Rm, 000=none.
REQ-008 The block SHALL have the port vsel, output, 2 bits: writeback source; 00=ALU result register C, 10=sximm8.
REQ-009 The block SHALL have the ports write, loada, loadb, loadc and loads, outputs, 1 bit each: register-file write, A/B/C register loads, status (Z,N,V) load.
REQ-010 The block SHALL have the ports asel and bsel, outputs, 1 bit each: asel=1 forces ALU A input to zero; bsel=1 selects immediate for B (always 0 in this block).
REQ-011 The block SHALL have the port ALU_op, output, 2 bits: 00 add, 01 subtract/compare, 10 and, 11 not-B.
REQ-012 The block SHALL have the port shift, output, 2 bits: shifter control for the B operand.
REQ-013 The block SHALL have the port sximm8, output, 16 bits: sign-extended in[7:0] of the captured instruction.

Function
REQ-014 Captured-instruction fields SHALL be: opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0], imm8=[7:0].
REQ-015 Legal encodings SHALL be: opcode 110/op 10 MOV-imm; 110/00 MOV-reg; 101/op any (00 ADD, 01 CMP, 10 AND, 11 MVN); all others illegal.
REQ-016 The FSM SHALL have states WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM, a 3-bit state register.
REQ-017 In WAIT with s=1, the block SHALL capture in into a 16-bit instruction register and enter DECODE; s=0 holds WAIT; s outside WAIT SHALL be ignored and in SHALL NOT be re-captured.
REQ-018 DECODE SHALL transition to WR_IMM on MOV-imm, to GET_B on MOV-reg or MVN, to GET_A on ADD/CMP/AND, and to WAIT on illegal, setting err.
REQ-019 err SHALL clear on the next accepted start and remain set otherwise.
REQ-020 GET_A SHALL assert nsel=100 and loada=1, then go to GET_B.
REQ-021 GET_B SHALL assert nsel=001 and loadb=1, then go to EXEC.
REQ-022 EXEC SHALL drive shift=sh, bsel=0, asel=1 for MOV-reg/MVN (else 0), ALU_op=00 for MOV-reg (else op), loadc=1 except CMP, loads=1 only for CMP; then CMP goes to WAIT, else WR_REG.
REQ-023 WR_REG SHALL assert nsel=010, vsel=00, write=1, then go to WAIT.
REQ-024 WR_IMM SHALL assert nsel=100, vsel=10, write=1, then go to WAIT.
REQ-025 Every control output not listed for the current state SHALL be 0 (shift=00, ALU_op=00, nsel=000, vsel=00).
REQ-026 Outputs SHALL be Moore functions of state and the instruction register only, glitch-independent of s/in.
REQ-027 sximm8 SHALL equal {8{imm8[7]}, imm8} from the instruction register at all times.
REQ-028 Cycles from the accepting edge to w high SHALL be: MOV-imm 2, MOV-reg/MVN/CMP 4, ADD/AND 5, illegal 1.
REQ-029 s held high continuously SHALL start a new instruction on the first edge after w rises (back-to-back, no idle cycle).

Reset
REQ-030 rst=1 SHALL immediately force state WAIT, instruction register 0, err=0, all controls 0, w=1, regardless of clock or state, including mid-instruction; no partial write SHALL be issued after reset deasserts.
REQ-031 After rst falls, the first rising clk with s=1 SHALL be accepted.

Verification
REQ-032 MOV-imm: in=16'hD2F0 (R2=-16), s pulse -> DECODE, WR_IMM nsel=100 vsel=10 write=1, sximm8=16'hFFF0, w high 2 cycles later.
REQ-033 ADD: in=16'hA0A1 (R5=R0+R1), s pulse -> loada (nsel=100), loadb (nsel=001), EXEC ALU_op=00 loadc=1 loads=0, WR_REG nsel=010 write=1; w after 5 cycles.
REQ-034 CMP: in=16'hA901 -> EXEC ALU_op=01 loads=1 loadc=0, no write cycle, w after 4 cycles.
REQ-035 MVN with shift: in=16'hB8B9 (sh=11) -> GET_A skipped, EXEC asel=1 ALU_op=11 shift=11, WR_REG; illegal in=16'h0000 -> err=1, w after 1 cycle, next legal start clears err.
REQ-036 rst asserted during EXEC of ADD -> all controls 0 and w=1 without waiting for clk; s during non-WAIT states and s held high across back-to-back MOV-imm both checked per REQ-017/REQ-029.

Source files
------------

// File: rtl/datapath_ctrl.sv
// Instruction-sequencing controller: captures an instruction on start, decodes it
// and steps the register-file/ALU datapath through read, execute and writeback.
module datapath_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic        err,
    output logic [2:0]  nsel,
    output logic [1:0]  vsel,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALU_op,
    output logic [1:0]  shift,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        WAIT   = 3'd0,
        DECODE = 3'd1,
        GET_A  = 3'd2,
        GET_B  = 3'd3,
        EXEC   = 3'd4,
        WR_REG = 3'd5,
        WR_IMM = 3'd6
    } state_t;

    typedef struct packed {
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] alu_op;
        logic [1:0] shift;
    } ctrl_t;

    state_t      state, state_n;
    logic [15:0] ir, ir_n;
    logic        err_n;
    ctrl_t       ctrl;

    // Control word for a given state; only legal instructions ever reach EXEC,
    // so opcode 110 there always means MOV-reg.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] instr);
        ctrl_t c;
        logic  is_mov, is_cmp;
        c      = '0;
        is_mov = (instr[15:13] == 3'b110);
        is_cmp = (instr[15:13] == 3'b101) && (instr[12:11] == 2'b01);
        case (st)
            GET_A: begin
                c.nsel  = 3'b100;
                c.loada = 1'b1;
            end
            GET_B: begin
                c.nsel  = 3'b001;
                c.loadb = 1'b1;
            end
            EXEC: begin
                c.shift  = instr[4:3];
                c.asel   = is_mov || (instr[12:11] == 2'b11);
                c.alu_op = is_mov ? 2'b00 : instr[12:11];
                c.loadc  = !is_cmp;
                c.loads  = is_cmp;
            end
            WR_REG: begin
                c.nsel  = 3'b010;
                c.write = 1'b1;
            end
            WR_IMM: begin
                c.nsel  = 3'b100;
                c.vsel  = 2'b10;
                c.write = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_n = state;
        ir_n    = ir;
        err_n   = err;
        case (state)
            WAIT: begin
                if (s) begin
                    ir_n    = in;
                    err_n   = 1'b0;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                case (ir[15:13])
                    3'b110: begin
                        if (ir[12:11] == 2'b10)      state_n = WR_IMM;
                        else if (ir[12:11] == 2'b00) state_n = GET_B;
                        else begin
                            state_n = WAIT;
                            err_n   = 1'b1;
                        end
                    end
                    3'b101:  state_n = (ir[12:11] == 2'b11) ? GET_B : GET_A;
                    default: begin
                        state_n = WAIT;
                        err_n   = 1'b1;
                    end
                endcase
            end
            GET_A:   state_n = GET_B;
            GET_B:   state_n = EXEC;
            EXEC:    state_n = ((ir[15:13] == 3'b101) && (ir[12:11] == 2'b01)) ? WAIT : WR_REG;
            WR_REG:  state_n = WAIT;
            WR_IMM:  state_n = WAIT;
            default: state_n = WAIT;
        endcase
    end

    // Outputs are registered from the next state so they are clean Moore values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT;
            ir    <= '0;
            err   <= 1'b0;
            ctrl  <= '0;
            w     <= 1'b1;
        end else begin
            state <= state_n;
            ir    <= ir_n;
            err   <= err_n;
            ctrl  <= ctrl_for(state_n, ir_n);
            w     <= (state_n == WAIT);
        end
    end

    assign nsel   = ctrl.nsel;
    assign vsel   = ctrl.vsel;
    assign write  = ctrl.write;
    assign loada  = ctrl.loada;
    assign loadb  = ctrl.loadb;
    assign loadc  = ctrl.loadc;
    assign loads  = ctrl.loads;
    assign asel   = ctrl.asel;
    assign bsel   = ctrl.bsel;
    assign ALU_op = ctrl.alu_op;
    assign shift  = ctrl.shift;
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule
